// File: rtl/regfile_wb_arbiter.sv
// Register-file write-back arbiter: ALU writes take the port immediately, LSU writes
// queue in a small FIFO and drain on idle ALU cycles; bypass lookup covers queued writes.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         alu_we,
  input  logic [AW-1:0]                alu_waddr,
  input  logic [DW-1:0]                alu_wdata,
  input  logic                         lsu_valid,
  input  logic [AW-1:0]                lsu_waddr,
  input  logic [DW-1:0]                lsu_wdata,
  output logic                         lsu_ready,
  output logic                         RegWrite,
  output logic [AW-1:0]                wraddr,
  output logic [DW-1:0]                wrdata,
  input  logic [AW-1:0]                chk_addr1,
  input  logic [AW-1:0]                chk_addr2,
  output logic                         chk_hit1,
  output logic [DW-1:0]                chk_data1,
  output logic                         chk_hit2,
  output logic [DW-1:0]                chk_data2,
  output logic                         pending,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    OCC_EMPTY,
    OCC_PARTIAL,
    OCC_FULL
  } occ_t;

  occ_t            occ_reg;
  logic [CW-1:0]   count_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [AW-1:0]   mem_addr [DEPTH];
  logic [DW-1:0]   mem_data [DEPTH];

  logic            reg_write_reg;
  logic [AW-1:0]   wraddr_reg;
  logic [DW-1:0]   wrdata_reg;

  logic            alu_sel;
  logic            push;
  logic            pop;

  // Register 0 writes are dropped here; LSU still sees its handshake complete.
  assign lsu_ready = (count_reg < CW'(DEPTH));
  assign alu_sel   = alu_we && (alu_waddr != '0);
  assign push      = lsu_valid && lsu_ready && (lsu_waddr != '0);
  assign pop       = !alu_sel && (occ_reg != OCC_EMPTY);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      occ_reg    <= OCC_EMPTY;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10: begin
          count_reg <= count_reg + 1'b1;
          occ_reg   <= (count_reg == CW'(DEPTH - 1)) ? OCC_FULL : OCC_PARTIAL;
        end
        2'b01: begin
          count_reg <= count_reg - 1'b1;
          occ_reg   <= (count_reg == CW'(1)) ? OCC_EMPTY : OCC_PARTIAL;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr[wr_ptr_reg] <= lsu_waddr;
      mem_data[wr_ptr_reg] <= lsu_wdata;
    end
  end

  // Output register: ALU wins, otherwise drain the FIFO head; address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_reg <= 1'b0;
      wraddr_reg    <= '0;
      wrdata_reg    <= '0;
    end else begin
      reg_write_reg <= alu_sel || pop;
      if (alu_sel) begin
        wraddr_reg <= alu_waddr;
        wrdata_reg <= alu_wdata;
      end else if (pop) begin
        wraddr_reg <= mem_addr[rd_ptr_reg];
        wrdata_reg <= mem_data[rd_ptr_reg];
      end
    end
  end

  assign RegWrite = reg_write_reg;
  assign wraddr   = wraddr_reg;
  assign wrdata   = wrdata_reg;
  assign count    = count_reg;
  assign pending  = reg_write_reg || (occ_reg != OCC_EMPTY);

  // Per-slot view ordered by age: offset 0 is the FIFO head (oldest).
  logic [AW-1:0]        chk_addr [2];
  logic [2*DEPTH-1:0]   match_all;
  logic [DW-1:0]        slot_data [DEPTH];

  assign chk_addr[0] = chk_addr1;
  assign chk_addr[1] = chk_addr2;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_slot
      logic [PW-1:0] idx;
      logic          live;
      assign idx                  = rd_ptr_reg + PW'(gi);
      assign live                 = (count_reg > CW'(gi));
      assign slot_data[gi]        = mem_data[idx];
      assign match_all[gi]        = live && (mem_addr[idx] == chk_addr1);
      assign match_all[DEPTH+gi]  = live && (mem_addr[idx] == chk_addr2);
    end

    for (gi = 0; gi < 2; gi++) begin : g_port
      logic          hit_c;
      logic [DW-1:0] data_c;
      // Later (younger) matches overwrite earlier ones, so the newest pending write wins.
      always_comb begin
        hit_c  = 1'b0;
        data_c = '0;
        if (reg_write_reg && (wraddr_reg == chk_addr[gi])) begin
          hit_c  = 1'b1;
          data_c = wrdata_reg;
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (match_all[gi*DEPTH + i]) begin
            hit_c  = 1'b1;
            data_c = slot_data[i];
          end
        end
        if (chk_addr[gi] == '0) begin
          hit_c  = 1'b0;
          data_c = '0;
        end
      end
    end
  endgenerate

  assign chk_hit1  = g_port[0].hit_c;
  assign chk_data1 = g_port[0].data_c;
  assign chk_hit2  = g_port[1].hit_c;
  assign chk_data2 = g_port[1].data_c;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alu_we = 1'b0;
  logic [AW-1:0] alu_waddr = '0;
  logic [DW-1:0] alu_wdata = '0;
  logic          lsu_valid = 1'b0;
  logic [AW-1:0] lsu_waddr = '0;
  logic [DW-1:0] lsu_wdata = '0;
  logic          lsu_ready;
  logic          RegWrite;
  logic [AW-1:0] wraddr;
  logic [DW-1:0] wrdata;
  logic [AW-1:0] chk_addr1 = '0;
  logic [AW-1:0] chk_addr2 = '0;
  logic          chk_hit1, chk_hit2;
  logic [DW-1:0] chk_data1, chk_data2;
  logic          pending;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .alu_we(alu_we), .alu_waddr(alu_waddr), .alu_wdata(alu_wdata),
    .lsu_valid(lsu_valid), .lsu_waddr(lsu_waddr), .lsu_wdata(lsu_wdata),
    .lsu_ready(lsu_ready),
    .RegWrite(RegWrite), .wraddr(wraddr), .wrdata(wrdata),
    .chk_addr1(chk_addr1), .chk_addr2(chk_addr2),
    .chk_hit1(chk_hit1), .chk_data1(chk_data1),
    .chk_hit2(chk_hit2), .chk_data2(chk_data2),
    .pending(pending), .count(count)
  );

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          q[$];
  logic          m_we   = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_we   = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic model_bypass(input logic [AW-1:0] ca, output logic hit, output logic [DW-1:0] data);
    hit  = 1'b0;
    data = '0;
    if (ca != '0) begin
      for (int i = q.size() - 1; i >= 0; i--) begin
        if (q[i].a == ca) begin
          hit  = 1'b1;
          data = q[i].d;
          break;
        end
      end
      if (!hit && m_we && m_addr == ca) begin
        hit  = 1'b1;
        data = m_data;
      end
    end
  endtask

  task automatic model_compare();
    logic          h;
    logic [DW-1:0] d;
    check("RegWrite", 32'(RegWrite), 32'(m_we));
    check("wraddr", 32'(wraddr), 32'(m_addr));
    check("wrdata", wrdata, m_data);
    check("count", 32'(count), 32'(q.size()));
    check("lsu_ready", 32'(lsu_ready), 32'(q.size() < DEPTH));
    check("pending", 32'(pending), 32'(m_we || q.size() != 0));
    model_bypass(chk_addr1, h, d);
    check("chk_hit1", 32'(chk_hit1), 32'(h));
    check("chk_data1", chk_data1, d);
    model_bypass(chk_addr2, h, d);
    check("chk_hit2", 32'(chk_hit2), 32'(h));
    check("chk_data2", chk_data2, d);
  endtask

  // Next-state of the write port from the current inputs, applied at the coming edge.
  task automatic model_step();
    int   pre;
    logic accept;
    ent_t e;
    if (!rst) begin
      model_reset();
      return;
    end
    pre    = q.size();
    accept = lsu_valid && (pre < DEPTH);
    if (alu_we && alu_waddr != '0) begin
      m_we = 1'b1; m_addr = alu_waddr; m_data = alu_wdata;
    end else if (pre > 0) begin
      e = q.pop_front();
      m_we = 1'b1; m_addr = e.a; m_data = e.d;
    end else begin
      m_we = 1'b0;
    end
    if (accept && lsu_waddr != '0) begin
      e.a = lsu_waddr;
      e.d = lsu_wdata;
      q.push_back(e);
    end
  endtask

  task automatic tick();
    model_compare();
    if (RegWrite)
      $display("cycle %0d: commit r%0d <= %h (fifo %0d)", cyc, wraddr, wrdata, count);
    model_step();
    cyc++;
    @(negedge clk);
  endtask

  task automatic drive(input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ld);
    alu_we = aw; alu_waddr = aa; alu_wdata = ad;
    lsu_valid = lv; lsu_waddr = la; lsu_wdata = ld;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic          acc;
    logic [AW-1:0] la;
    logic [AW-1:0] got[$];

    // Reset state
    @(negedge clk);
    #1;
    check("rst_RegWrite", 32'(RegWrite), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_ready", 32'(lsu_ready), 32'd1);
    check("rst_wraddr", 32'(wraddr), 32'd0);
    check("rst_wrdata", wrdata, 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    tick();
    rst = 1'b1;
    drive(0, 5'd0, 0, 0, 5'd0, 0); #1; tick();

    // T1: single ALU write, one-cycle latency
    drive(1, 5'd3, 32'hDEADBEEF, 0, 5'd0, 0); #1; tick();
    drive(0, 5'd0, 0, 0, 5'd0, 0); #1;
    check("t1_we", 32'(RegWrite), 32'd1);
    check("t1_addr", 32'(wraddr), 32'd3);
    check("t1_data", wrdata, 32'hDEADBEEF);
    tick();
    #1;
    check("t1_we_off", 32'(RegWrite), 32'd0);
    tick();

    // T2: ALU holds the port, LSU fills the FIFO then drains in order
    la = 5'd4;
    for (int k = 0; k < 5; k++) begin
      drive(1, 5'd1, 32'h100 + k, 1, la, 32'h400 + 32'(la)); #1;
      if (k == 4) begin
        check("t2_ready_full", 32'(lsu_ready), 32'd0);
        check("t2_count_full", 32'(count), 32'd4);
      end
      acc = lsu_ready;
      tick();
      if (acc) la = la + 5'd1;
    end
    for (int k = 0; k < 10; k++) begin
      drive(0, 5'd0, 0, (la <= 5'd8), la, 32'h400 + 32'(la)); #1;
      if (RegWrite && wraddr >= 5'd4) got.push_back(wraddr);
      acc = lsu_ready && (la <= 5'd8);
      tick();
      if (acc) la = la + 5'd1;
    end
    check("t2_ncommits", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size() && i < 5; i++)
      check("t2_order", 32'(got[i]), 32'(4 + i));

    // T3: register-0 writes from both sources are discarded
    drive(1, 5'd0, 32'hAA, 1, 5'd0, 32'hBB); #1;
    check("t3_ready", 32'(lsu_ready), 32'd1);
    tick();
    drive(0, 5'd0, 0, 0, 5'd0, 0); #1;
    check("t3_we", 32'(RegWrite), 32'd0);
    check("t3_count", 32'(count), 32'd0);
    tick();

    // T4: bypass returns the newest FIFO entry; address 0 never hits
    drive(1, 5'd2, 32'h2, 1, 5'd7, 32'h11); #1; tick();
    drive(1, 5'd2, 32'h3, 1, 5'd7, 32'h22); #1; tick();
    drive(1, 5'd2, 32'h4, 0, 5'd0, 0);
    chk_addr1 = 5'd7; chk_addr2 = 5'd0; #1;
    check("t4_hit1", 32'(chk_hit1), 32'd1);
    check("t4_data1", chk_data1, 32'h22);
    check("t4_hit2", 32'(chk_hit2), 32'd0);
    check("t4_data2", chk_data2, 32'h0);
    chk_addr2 = 5'd2; #1;
    check("t4_hit_outreg", 32'(chk_hit2), 32'd1);
    check("t4_data_outreg", chk_data2, 32'h3);
    tick();
    chk_addr1 = '0; chk_addr2 = '0;

    // T5: push and pop in the same cycle at count=3
    drive(1, 5'd2, 32'h5, 1, 5'd9, 32'h33); #1; tick();
    drive(0, 5'd0, 0, 1, 5'd10, 32'h44); #1;
    check("t5_count_before", 32'(count), 32'd3);
    tick();
    drive(0, 5'd0, 0, 0, 5'd0, 0); #1;
    check("t5_count_after", 32'(count), 32'd3);
    check("t5_c0_addr", 32'(wraddr), 32'd7);
    check("t5_c0_data", wrdata, 32'h11);
    tick(); #1;
    check("t5_c1_data", wrdata, 32'h22);
    tick(); #1;
    check("t5_c2_addr", 32'(wraddr), 32'd9);
    check("t5_c2_data", wrdata, 32'h33);
    tick(); #1;
    check("t5_c3_addr", 32'(wraddr), 32'd10);
    check("t5_c3_data", wrdata, 32'h44);
    tick();

    // T6: asynchronous reset clears state without a clock edge
    drive(1, 5'd2, 32'h55, 1, 5'd11, 32'h61); #1; tick();
    drive(1, 5'd2, 32'h56, 1, 5'd12, 32'h62); #1; tick();
    drive(1, 5'd2, 32'h57, 1, 5'd13, 32'h63); #1; tick();
    drive(1, 5'd2, 32'h58, 0, 5'd0, 0); #1;
    check("t6_count_pre", 32'(count), 32'd3);
    check("t6_we_pre", 32'(RegWrite), 32'd1);
    rst = 1'b0; #1;
    check("t6_we", 32'(RegWrite), 32'd0);
    check("t6_count", 32'(count), 32'd0);
    check("t6_ready", 32'(lsu_ready), 32'd1);
    check("t6_wraddr", 32'(wraddr), 32'd0);
    check("t6_pending", 32'(pending), 32'd0);
    model_reset();
    tick();
    rst = 1'b1;

    // Randomized traffic with one mid-cycle asynchronous reset
    for (int i = 0; i < 800; i++) begin
      if (!rst) rst = 1'b1;
      alu_we    = ($urandom % 3) == 0;
      alu_waddr = 5'($urandom_range(0, 7));
      alu_wdata = $urandom;
      lsu_valid = ($urandom % 2) == 0;
      lsu_waddr = 5'($urandom_range(0, 7));
      lsu_wdata = $urandom;
      chk_addr1 = 5'($urandom_range(0, 7));
      chk_addr2 = 5'($urandom_range(0, 7));
      #1;
      if (i == 400) begin
        rst = 1'b0; #1;
        model_reset();
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
